// File: rtl/nh_lcd_frame_sequencer_pkg.sv
// Shared definitions for the LCD frame sequencer: states, opcodes, window byte helper.
package nh_lcd_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_BYTE,
        COL_CMD,
        COL_PARAM,
        PAGE_CMD,
        PAGE_PARAM,
        STREAM,
        DONE
    } seq_state_t;

    localparam logic [7:0] OP_COL_ADDR  = 8'h2A;
    localparam logic [7:0] OP_PAGE_ADDR = 8'h2B;
    localparam logic [7:0] OP_MEM_WRITE = 8'h2C;

    // Address window parameter bytes: start = 0x0000, end = extent-1 (MSB first).
    function automatic logic [7:0] window_byte(input logic [1:0] idx, input logic [15:0] extent);
        logic [15:0] last_pos;
        last_pos = extent - 16'd1;
        case (idx)
            2'd2:    window_byte = last_pos[15:8];
            2'd3:    window_byte = last_pos[7:0];
            default: window_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nh_lcd_byte_issuer.sv
// Issues one byte on the 8080 pins: held BYTE_CYCLES clocks, write strobe in the first only.
module nh_lcd_byte_issuer #(
    parameter int unsigned BYTE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       cmd_mode,
    output logic       pin_cmd_mode,
    output logic       pin_write,
    output logic [7:0] pin_data,
    output logic       done
);

    localparam logic [3:0] LAST = 4'(BYTE_CYCLES - 1);

    logic       active;
    logic [3:0] remaining;

    // Latch the byte on start, then count down its hold time; pins idle afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            active       <= 1'b0;
            remaining    <= '0;
            pin_cmd_mode <= 1'b1;
            pin_write    <= 1'b0;
            pin_data     <= '0;
        end else if (!active) begin
            pin_write <= 1'b0;
            if (start) begin
                active       <= 1'b1;
                remaining    <= LAST;
                pin_data     <= data;
                pin_cmd_mode <= cmd_mode;
                pin_write    <= 1'b1;
            end
        end else begin
            pin_write <= 1'b0;
            if (remaining == '0) begin
                active       <= 1'b0;
                pin_cmd_mode <= 1'b1;
            end else begin
                remaining <= remaining - 4'd1;
            end
        end
    end

    assign done = active && (remaining == '0);

endmodule

// File: rtl/nh_lcd_frame_sequencer.sv
// LCD bus owner: host byte writes, per-frame address window programming, pixel stream handoff.
module nh_lcd_frame_sequencer
    import nh_lcd_frame_sequencer_pkg::*;
#(
    parameter int unsigned BYTE_CYCLES   = 2,
    parameter logic [7:0]  CMD_COL_ADDR  = OP_COL_ADDR,
    parameter logic [7:0]  CMD_PAGE_ADDR = OP_PAGE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_continuous,
    input  logic        i_frame_stb,
    input  logic [15:0] i_width,
    input  logic [15:0] i_height,
    input  logic        i_cmd_stb,
    input  logic        i_cmd_is_cmd,
    input  logic [7:0]  i_cmd_data,
    output logic        o_cmd_rdy,
    output logic        o_writer_en,
    output logic [31:0] o_num_pixels,
    input  logic        i_wr_cmd_mode,
    input  logic        i_wr_write,
    input  logic [7:0]  i_wr_data,
    output logic        o_cmd_mode,
    output logic        o_write,
    output logic [7:0]  o_data_out,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_abort,
    output logic [31:0] o_frame_count
);

    seq_state_t  state;
    logic        launched;
    logic [1:0]  idx;
    logic [7:0]  host_data;
    logic        host_cmd_mode;
    logic [31:0] strokes;

    logic        frame_byte_state;
    logic        frame_req;
    logic        issue_start;
    logic [7:0]  issue_data;
    logic        issue_cmd_mode;
    logic        issue_done;
    logic        seq_cmd_mode;
    logic        seq_write;
    logic [7:0]  seq_data;
    logic [33:0] stroke_target;

    assign frame_byte_state = (state == COL_CMD) || (state == COL_PARAM) ||
                              (state == PAGE_CMD) || (state == PAGE_PARAM);
    assign frame_req = i_enable && (i_continuous || i_frame_stb) &&
                       (i_width != '0) && (i_height != '0);
    // Frame bytes are not launched once disabled, so an abort never leaves a byte half-sent.
    assign issue_start = !launched && ((state == HOST_BYTE) || (frame_byte_state && i_enable));
    assign stroke_target = 34'(o_num_pixels) * 34'd3;

    // Select the byte the sequencer issues in the current state.
    always_comb begin
        issue_data     = '0;
        issue_cmd_mode = 1'b1;
        case (state)
            HOST_BYTE: begin
                issue_data     = host_data;
                issue_cmd_mode = host_cmd_mode;
            end
            COL_CMD: begin
                issue_data     = CMD_COL_ADDR;
                issue_cmd_mode = 1'b0;
            end
            COL_PARAM:  issue_data = window_byte(idx, i_width);
            PAGE_CMD: begin
                issue_data     = CMD_PAGE_ADDR;
                issue_cmd_mode = 1'b0;
            end
            PAGE_PARAM: issue_data = window_byte(idx, i_height);
            default: ;
        endcase
    end

    nh_lcd_byte_issuer #(
        .BYTE_CYCLES(BYTE_CYCLES)
    ) u_issuer (
        .clk         (clk),
        .rst         (rst),
        .start       (issue_start),
        .data        (issue_data),
        .cmd_mode    (issue_cmd_mode),
        .pin_cmd_mode(seq_cmd_mode),
        .pin_write   (seq_write),
        .pin_data    (seq_data),
        .done        (issue_done)
    );

    assign o_cmd_mode  = (state == STREAM) ? i_wr_cmd_mode : seq_cmd_mode;
    assign o_write     = (state == STREAM) ? i_wr_write    : seq_write;
    assign o_data_out  = (state == STREAM) ? i_wr_data     : seq_data;
    assign o_writer_en = (state == STREAM);
    assign o_busy      = (state != IDLE);

    // Frame/host sequencing FSM with registered status pulses and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            launched      <= 1'b0;
            idx           <= '0;
            host_data     <= '0;
            host_cmd_mode <= 1'b1;
            strokes       <= '0;
            o_num_pixels  <= '0;
            o_frame_count <= '0;
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            o_cmd_rdy     <= 1'b0;
        end else begin
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            if (issue_start) launched <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_cmd_stb) begin
                        host_data     <= i_cmd_data;
                        host_cmd_mode <= ~i_cmd_is_cmd;
                        state         <= HOST_BYTE;
                        o_cmd_rdy     <= 1'b0;
                    end else if (frame_req) begin
                        o_num_pixels <= 32'(i_width) * 32'(i_height);
                        strokes      <= '0;
                        idx          <= '0;
                        state        <= COL_CMD;
                        o_cmd_rdy    <= 1'b0;
                    end else begin
                        o_cmd_rdy <= 1'b1;
                    end
                end
                HOST_BYTE: begin
                    if (issue_done) begin
                        launched  <= 1'b0;
                        state     <= IDLE;
                        o_cmd_rdy <= 1'b1;
                    end
                end
                COL_CMD, COL_PARAM, PAGE_CMD, PAGE_PARAM: begin
                    if (!i_enable && (!launched || issue_done)) begin
                        launched      <= 1'b0;
                        state         <= IDLE;
                        o_frame_abort <= 1'b1;
                        o_cmd_rdy     <= 1'b1;
                    end else if (issue_done) begin
                        launched <= 1'b0;
                        idx      <= idx + 2'd1;
                        if (state == COL_CMD) begin
                            idx   <= '0;
                            state <= COL_PARAM;
                        end else if (state == PAGE_CMD) begin
                            idx   <= '0;
                            state <= PAGE_PARAM;
                        end else if (idx == 2'd3) begin
                            state <= (state == COL_PARAM) ? PAGE_CMD : STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (!i_enable) begin
                        state         <= IDLE;
                        o_frame_abort <= 1'b1;
                        o_cmd_rdy     <= 1'b1;
                    end else if (i_wr_write && i_wr_cmd_mode) begin
                        strokes <= strokes + 32'd1;
                        if (({2'b00, strokes} + 34'd1) == stroke_target) begin
                            state         <= DONE;
                            o_frame_done  <= 1'b1;
                            o_frame_count <= o_frame_count + 32'd1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    o_cmd_rdy <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nh_lcd_frame_sequencer.sv
// Directed self-checking bench for nh_lcd_frame_sequencer (BYTE_CYCLES = 2).
module tb_nh_lcd_frame_sequencer;
    import nh_lcd_frame_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable, i_continuous, i_frame_stb;
    logic [15:0] i_width, i_height;
    logic        i_cmd_stb, i_cmd_is_cmd;
    logic [7:0]  i_cmd_data;
    logic        o_cmd_rdy, o_writer_en;
    logic [31:0] o_num_pixels;
    logic        i_wr_cmd_mode, i_wr_write;
    logic [7:0]  i_wr_data;
    logic        o_cmd_mode, o_write;
    logic [7:0]  o_data_out;
    logic        o_busy, o_frame_done, o_frame_abort;
    logic [31:0] o_frame_count;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    logic [8:0]  seq_bytes[$];
    int unsigned done_pulses  = 0;
    int unsigned abort_pulses = 0;

    always #5 clk = ~clk;

    nh_lcd_frame_sequencer #(
        .BYTE_CYCLES  (2),
        .CMD_COL_ADDR (8'h2A),
        .CMD_PAGE_ADDR(8'h2B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_continuous (i_continuous),
        .i_frame_stb  (i_frame_stb),
        .i_width      (i_width),
        .i_height     (i_height),
        .i_cmd_stb    (i_cmd_stb),
        .i_cmd_is_cmd (i_cmd_is_cmd),
        .i_cmd_data   (i_cmd_data),
        .o_cmd_rdy    (o_cmd_rdy),
        .o_writer_en  (o_writer_en),
        .o_num_pixels (o_num_pixels),
        .i_wr_cmd_mode(i_wr_cmd_mode),
        .i_wr_write   (i_wr_write),
        .i_wr_data    (i_wr_data),
        .o_cmd_mode   (o_cmd_mode),
        .o_write      (o_write),
        .o_data_out   (o_data_out),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_frame_abort(o_frame_abort),
        .o_frame_count(o_frame_count)
    );

    // Record every sequencer-issued byte and count status pulses.
    always @(negedge clk) begin
        if (o_write && !o_writer_en) seq_bytes.push_back({o_cmd_mode, o_data_out});
        if (o_frame_done) done_pulses = done_pulses + 1;
        if (o_frame_abort) abort_pulses = abort_pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_enable = 1'b0; i_continuous = 1'b0; i_frame_stb = 1'b0;
        i_width = 16'd1; i_height = 16'd1;
        i_cmd_stb = 1'b0; i_cmd_is_cmd = 1'b0; i_cmd_data = 8'h00;
        i_wr_cmd_mode = 1'b1; i_wr_write = 1'b0; i_wr_data = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        step(); step();
        rst = 1'b0;
        step();
        seq_bytes.delete();
        done_pulses = 0;
        abort_pulses = 0;
    endtask

    task automatic wait_writer_en(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_writer_en) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_writer_en_timeout: o_writer_en=%0b required 1 within 300 cycles", tag, o_writer_en);
        end
    endtask

    task automatic stroke(input logic mode, input logic [7:0] data);
        i_wr_write = 1'b1; i_wr_cmd_mode = mode; i_wr_data = data;
        step();
        i_wr_write = 1'b0; i_wr_cmd_mode = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step(); step();
        checks++;
        if ({o_cmd_mode, o_write, o_data_out} !== {1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_pins: got cmd_mode=%0b write=%0b data=%h required 1 0 00", o_cmd_mode, o_write, o_data_out);
        end
        checks++;
        if ({o_writer_en, o_cmd_rdy, o_busy, o_frame_done, o_frame_abort} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_flags: got wen=%0b rdy=%0b busy=%0b done=%0b abort=%0b required all 0",
                     o_writer_en, o_cmd_rdy, o_busy, o_frame_done, o_frame_abort);
        end
        checks++;
        if ({o_frame_count, o_num_pixels} !== 64'd0) begin
            fails++;
            $display("FAIL reset_counters: got frame_count=%0d num_pixels=%0d required 0 0", o_frame_count, o_num_pixels);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_cmd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_cmd_rdy_after: got %0b required 1", o_cmd_rdy);
        end
    endtask

    task automatic test_host_byte();
        seq_bytes.delete();
        i_cmd_stb = 1'b1; i_cmd_is_cmd = 1'b1; i_cmd_data = 8'h11;
        step();
        i_cmd_stb = 1'b0;
        checks++;
        if ({o_cmd_rdy, o_busy, o_write} !== 3'b010) begin
            fails++;
            $display("FAIL host_accept: got rdy=%0b busy=%0b write=%0b required 0 1 0", o_cmd_rdy, o_busy, o_write);
        end
        step();
        checks++;
        if ({o_write, o_cmd_mode, o_data_out} !== {1'b1, 1'b0, 8'h11}) begin
            fails++;
            $display("FAIL host_first_clock: got write=%0b cmd_mode=%0b data=%h required 1 0 11", o_write, o_cmd_mode, o_data_out);
        end
        step();
        checks++;
        if ({o_write, o_cmd_mode, o_data_out, o_cmd_rdy} !== {1'b0, 1'b0, 8'h11, 1'b0}) begin
            fails++;
            $display("FAIL host_second_clock: got write=%0b cmd_mode=%0b data=%h rdy=%0b required 0 0 11 0",
                     o_write, o_cmd_mode, o_data_out, o_cmd_rdy);
        end
        step();
        checks++;
        if ({o_write, o_cmd_mode, o_data_out, o_cmd_rdy, o_busy} !== {1'b0, 1'b1, 8'h11, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL host_release: got write=%0b cmd_mode=%0b data=%h rdy=%0b busy=%0b required 0 1 11 1 0",
                     o_write, o_cmd_mode, o_data_out, o_cmd_rdy, o_busy);
        end
        checks++;
        if (seq_bytes.size() != 1) begin
            fails++;
            $display("FAIL host_stroke_count: got %0d strokes required 1", seq_bytes.size());
        end
    endtask

    task automatic test_window();
        logic [8:0] exp_win [10];
        logic [8:0] got;
        exp_win = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F};
        seq_bytes.delete();
        i_width = 16'd240; i_height = 16'd320; i_enable = 1'b1; i_continuous = 1'b0;
        i_frame_stb = 1'b1;
        step();
        i_frame_stb = 1'b0;
        wait_writer_en("window");
        checks++;
        if (seq_bytes.size() != 10) begin
            fails++;
            $display("FAIL window_len: got %0d bytes required 10", seq_bytes.size());
        end
        for (int i = 0; i < 10; i++) begin
            got = (i < seq_bytes.size()) ? seq_bytes[i] : 9'h1FF;
            checks++;
            if (got !== exp_win[i]) begin
                fails++;
                $display("FAIL window_byte%0d: got mode=%0b data=%h required mode=%0b data=%h",
                         i, got[8], got[7:0], exp_win[i][8], exp_win[i][7:0]);
            end
        end
        checks++;
        if (o_num_pixels !== 32'd76800) begin
            fails++;
            $display("FAIL window_num_pixels: got %0d required 76800", o_num_pixels);
        end
        i_enable = 1'b0;
        step();
        checks++;
        if ({o_frame_abort, o_busy, o_writer_en} !== 3'b100) begin
            fails++;
            $display("FAIL window_stream_abort: got abort=%0b busy=%0b wen=%0b required 1 0 0", o_frame_abort, o_busy, o_writer_en);
        end
    endtask

    task automatic test_end_of_frame();
        apply_reset();
        i_width = 16'd2; i_height = 16'd2; i_enable = 1'b1;
        i_frame_stb = 1'b1;
        step();
        i_frame_stb = 1'b0;
        wait_writer_en("eof");
        stroke(1'b0, OP_MEM_WRITE);
        for (int i = 0; i < 11; i++) stroke(1'b1, 8'(i));
        checks++;
        if ({done_pulses, o_writer_en} !== {32'd0, 1'b1}) begin
            fails++;
            $display("FAIL eof_early: got done_pulses=%0d wen=%0b after 11 strokes required 0 1", done_pulses, o_writer_en);
        end
        i_wr_write = 1'b1; i_wr_cmd_mode = 1'b1; i_wr_data = 8'hC0;
        #1;
        checks++;
        if ({o_write, o_cmd_mode, o_data_out} !== {1'b1, 1'b1, 8'hC0}) begin
            fails++;
            $display("FAIL eof_passthrough: got write=%0b mode=%0b data=%h required 1 1 c0", o_write, o_cmd_mode, o_data_out);
        end
        step();
        i_wr_write = 1'b0;
        checks++;
        if ({o_frame_done, o_writer_en, o_frame_count} !== {1'b1, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL eof_done: got done=%0b wen=%0b count=%0d required 1 0 1", o_frame_done, o_writer_en, o_frame_count);
        end
        step();
        checks++;
        if ({o_frame_done, o_busy, o_frame_count} !== {1'b0, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL eof_idle: got done=%0b busy=%0b count=%0d required 0 0 1", o_frame_done, o_busy, o_frame_count);
        end
    endtask

    task automatic test_continuous();
        apply_reset();
        i_width = 16'd1; i_height = 16'd1; i_enable = 1'b1; i_continuous = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_writer_en("cont");
            for (int s = 0; s < 3; s++) stroke(1'b1, 8'hA0);
        end
        i_continuous = 1'b0;
        step(); step();
        checks++;
        if ({done_pulses, o_frame_count, o_busy} !== {32'd3, 32'd3, 1'b0}) begin
            fails++;
            $display("FAIL cont_frames: got pulses=%0d count=%0d busy=%0b required 3 3 0", done_pulses, o_frame_count, o_busy);
        end
        checks++;
        if (seq_bytes.size() != 30) begin
            fails++;
            $display("FAIL cont_bytes: got %0d bytes required 30", seq_bytes.size());
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (seq_bytes.size() < 30 || seq_bytes[10*f] !== 9'h02A || seq_bytes[10*f+5] !== 9'h02B) begin
                fails++;
                $display("FAIL cont_window%0d: window opcodes missing or wrong before frame %0d", f, f);
            end
        end
    endtask

    task automatic test_abort();
        apply_reset();
        i_width = 16'd2; i_height = 16'd2; i_enable = 1'b1;
        i_frame_stb = 1'b1;
        step();
        i_frame_stb = 1'b0;
        wait_writer_en("abort");
        for (int i = 0; i < 5; i++) stroke(1'b1, 8'h55);
        i_enable = 1'b0;
        step();
        checks++;
        if ({o_frame_abort, o_busy, o_writer_en, o_frame_done, o_frame_count} !== {4'b1000, 32'd0}) begin
            fails++;
            $display("FAIL abort_pulse: got abort=%0b busy=%0b wen=%0b done=%0b count=%0d required 1 0 0 0 0",
                     o_frame_abort, o_busy, o_writer_en, o_frame_done, o_frame_count);
        end
        step();
        checks++;
        if ({o_frame_abort, abort_pulses} !== {1'b0, 32'd1}) begin
            fails++;
            $display("FAIL abort_single: got abort=%0b pulses=%0d required 0 1", o_frame_abort, abort_pulses);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit reached;
        seq_bytes.delete();
        reached = 1'b0;
        i_width = 16'h1235; i_height = 16'd320; i_enable = 1'b1;
        i_frame_stb = 1'b1;
        step();
        i_frame_stb = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (seq_bytes.size() >= 4) begin reached = 1'b1; break; end
        end
        checks++;
        if (!reached || o_data_out !== 8'h12 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_reach: got reached=%0b data=%h busy=%0b required 1 12 1", reached, o_data_out, o_busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({o_cmd_mode, o_write, o_data_out, o_writer_en, o_cmd_rdy, o_busy} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            fails++;
            $display("FAIL rstmid_pins: got mode=%0b write=%0b data=%h wen=%0b rdy=%0b busy=%0b required 1 0 00 0 0 0",
                     o_cmd_mode, o_write, o_data_out, o_writer_en, o_cmd_rdy, o_busy);
        end
        checks++;
        if ({o_frame_count, o_num_pixels} !== 64'd0) begin
            fails++;
            $display("FAIL rstmid_counters: got count=%0d pixels=%0d required 0 0", o_frame_count, o_num_pixels);
        end
        rst = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_contention();
        bit reached;
        apply_reset();
        reached = 1'b0;
        i_width = 16'd4; i_height = 16'd4; i_enable = 1'b1;
        i_cmd_stb = 1'b1; i_cmd_is_cmd = 1'b0; i_cmd_data = 8'h55;
        i_frame_stb = 1'b1;
        step();
        i_cmd_stb = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (seq_bytes.size() >= 2) begin reached = 1'b1; break; end
        end
        i_frame_stb = 1'b0;
        checks++;
        if (!reached || seq_bytes[0] !== 9'h155 || seq_bytes[1] !== 9'h02A) begin
            fails++;
            $display("FAIL contention_order: got reached=%0b first=%h second=%h required 1 155 02a",
                     reached, reached ? seq_bytes[0] : 9'h0, reached ? seq_bytes[1] : 9'h0);
        end
        i_enable = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if ({o_busy, abort_pulses} !== {1'b0, 32'd1}) begin
            fails++;
            $display("FAIL contention_abort: got busy=%0b aborts=%0d required 0 1", o_busy, abort_pulses);
        end
    endtask

    task automatic test_zero_height();
        i_width = 16'd4; i_height = 16'd0; i_enable = 1'b1;
        i_frame_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o_busy !== 1'b0) begin
                fails++;
                $display("FAIL zero_height_busy%0d: got busy=%0b required 0", i, o_busy);
            end
        end
        i_frame_stb = 1'b0;
        i_width = 16'd0; i_height = 16'd4; i_continuous = 1'b1;
        step(); step();
        checks++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_width_busy: got busy=%0b required 0", o_busy);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_host_byte();
        test_window();
        test_end_of_frame();
        test_continuous();
        test_reset_mid_frame();
        test_abort();
        test_contention();
        test_zero_height();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
